// File: rtl/sseg_scan_decoder_if.sv
// Bus bundle between a multiplexed seven-segment tap and its scan decoder.
// master drives the anode/cathode tap and observes results; slave is the decoder side.
interface sseg_scan_decoder_if;
  logic [3:0]  sseg_a_i;
  logic [6:0]  sseg_c_i;
  logic [15:0] bcd_o;
  logic        frame_valid_o;
  logic        frame_err_o;
  logic [3:0]  digit_seen_o;

  modport master (
    output sseg_a_i,
    output sseg_c_i,
    input  bcd_o,
    input  frame_valid_o,
    input  frame_err_o,
    input  digit_seen_o
  );

  modport slave (
    input  sseg_a_i,
    input  sseg_c_i,
    output bcd_o,
    output frame_valid_o,
    output frame_err_o,
    output digit_seen_o
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Reconstructs the 4-digit BCD value shown on a tapped multiplexed seven-segment bus.
// Define SSEG_HEX_DECODE_EN to also accept the hex glyphs A..F as error-free nibbles.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                clk,
  input logic                reset,
  sseg_scan_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_qq;
  logic [6:0]       c_q, c_qq;
  logic [15:0]      shadow_q;
  logic [3:0]       seen_q, seen_d;
  logic             err_acc_q, err_acc_d;
  logic [15:0]      bcd_q;
  logic             frame_valid_q, frame_err_q;
  logic             active, changed, capture, frame_done;
  logic [1:0]       slot;
  logic [3:0]       nibble;
  logic             dec_err;

  // Returns {error, nibble} for an active-low {g..a} glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] glyph);
    logic [4:0] res;
    res = {1'b1, 4'hF};
    unique case (glyph)
      7'h40:   res = {1'b0, 4'h0};
      7'h79:   res = {1'b0, 4'h1};
      7'h24:   res = {1'b0, 4'h2};
      7'h30:   res = {1'b0, 4'h3};
      7'h19:   res = {1'b0, 4'h4};
      7'h12:   res = {1'b0, 4'h5};
      7'h02:   res = {1'b0, 4'h6};
      7'h78:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h10:   res = {1'b0, 4'h9};
`ifdef SSEG_HEX_DECODE_EN
      7'h08:   res = {1'b0, 4'hA};
      7'h03:   res = {1'b0, 4'hB};
      7'h46:   res = {1'b0, 4'hC};
      7'h21:   res = {1'b0, 4'hD};
      7'h06:   res = {1'b0, 4'hE};
      7'h0E:   res = {1'b0, 4'hF};
`endif
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  assign active  = $onehot(~a_q);
  assign changed = {a_q, c_q} != {a_qq, c_qq};
  assign {dec_err, nibble} = decode_glyph(c_q);

  always_comb begin
    slot = 2'd0;
    unique case (a_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (active) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end
      end
      StSettle: begin
        if (!active) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (!active) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Any path that reaches the threshold captures immediately, including STABLE_CYCLES == 1.
    if (state_d == StSettle && cnt_d >= StableCnt) begin
      capture = 1'b1;
      state_d = StHold;
    end
  end

  // A capture on the frame-clear edge is credited to the following frame.
  always_comb begin
    frame_done = (seen_q == 4'hF);
    seen_d     = frame_done ? 4'h0 : seen_q;
    err_acc_d  = frame_done ? 1'b0 : err_acc_q;
    if (capture) begin
      seen_d[slot] = 1'b1;
      err_acc_d    = err_acc_d | dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q           <= 4'hF;
      a_qq          <= 4'hF;
      c_q           <= 7'h7F;
      c_qq          <= 7'h7F;
      state_q       <= StIdle;
      cnt_q         <= '0;
      shadow_q      <= '0;
      seen_q        <= '0;
      err_acc_q     <= 1'b0;
      bcd_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      a_q           <= bus.sseg_a_i;
      c_q           <= bus.sseg_c_i;
      a_qq          <= a_q;
      c_qq          <= c_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      err_acc_q     <= err_acc_d;
      frame_valid_q <= frame_done;
      if (frame_done) begin
        bcd_q       <= shadow_q;
        frame_err_q <= err_acc_q;
      end
      if (capture) begin
        shadow_q[{slot, 2'b00} +: 4] <= nibble;
      end
    end
  end

  assign bus.bcd_o         = bcd_q;
  assign bus.frame_valid_o = frame_valid_q;
  assign bus.frame_err_o   = frame_err_q;
  assign bus.digit_seen_o  = seen_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Randomized bench for sseg_scan_decoder against an interval-level reference model.
// Honours SSEG_HEX_DECODE_EN the same way as the design.
module tb_sseg_scan_decoder;

  localparam int unsigned S = 4;

`ifdef SSEG_HEX_DECODE_EN
  localparam bit HexEn = 1'b1;
`else
  localparam bit HexEn = 1'b0;
`endif

  // Active-low glyphs for values 0..F.
  localparam logic [6:0] Glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    int unsigned at;
    logic [1:0]  slot;
    logic [3:0]  nib;
    logic        err;
  } cap_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_scan_decoder_if bus ();

  sseg_scan_decoder #(
    .STABLE_CYCLES(S),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned edge_n   = 0;
  cap_t        capq[$];
  logic [15:0] m_bcd;
  logic        m_valid, m_err, m_acc;
  logic [3:0]  m_seen;
  logic [3:0]  m_shadow [4];
  logic [10:0] prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] c);
    for (int i = 0; i < 16; i++) begin
      if (Glyph[i] == c && (i < 10 || HexEn)) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    m_bcd   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_acc   = 1'b0;
    m_seen  = '0;
    for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    capq.delete();
    prev = {4'hF, 7'h7F};
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic step();
    cap_t c;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      model_reset();
    end else begin
      m_valid = 1'b0;
      if (m_seen == 4'hF) begin
        m_bcd   = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
        m_err   = m_acc;
        m_valid = 1'b1;
        m_seen  = '0;
        m_acc   = 1'b0;
      end
      if (capq.size() > 0 && capq[0].at == edge_n) begin
        c = capq.pop_front();
        m_shadow[c.slot] = c.nib;
        m_seen[c.slot]   = 1'b1;
        m_acc            = m_acc | c.err;
      end
    end
    #1;
    check("frame_valid", 32'(bus.frame_valid_o), 32'(m_valid));
    check("bcd", 32'(bus.bcd_o), 32'(m_bcd));
    check("frame_err", 32'(bus.frame_err_o), 32'(m_err));
    check("digit_seen", 32'(bus.digit_seen_o), 32'(m_seen));
  endtask

  // Holds {a,c} for dwell edges; a held one-hot digit is taken S+1 edges after it appears.
  task automatic show(input logic [3:0] a, input logic [6:0] c, input int unsigned dwell);
    cap_t       e;
    logic [4:0] d;
    bus.sseg_a_i = a;
    bus.sseg_c_i = c;
    if ($countones(~a) == 1 && dwell >= S && {a, c} != prev) begin
      d      = ref_decode(c);
      e.at   = edge_n + S + 1;
      e.slot = 2'd0;
      for (int i = 0; i < 4; i++) if (!a[i]) e.slot = 2'(i);
      e.nib  = d[3:0];
      e.err  = d[4];
      capq.push_back(e);
    end
    prev = {a, c};
    repeat (dwell) step();
  endtask

  task automatic scan(input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                      input logic [6:0] g0, input int unsigned dwell);
    show(4'b0111, g3, dwell);
    show(4'b1011, g2, dwell);
    show(4'b1101, g1, dwell);
    show(4'b1110, g0, dwell);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  ra;
    logic [6:0]  rc;
    logic [3:0]  two_hot [4] = '{4'b1100, 4'b0101, 4'b1010, 4'b0011};
    int unsigned r;

    bus.sseg_a_i = 4'hF;
    bus.sseg_c_i = 7'h7F;
    reset        = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_bcd", 32'(bus.bcd_o), 32'h0);
    check("reset_seen", 32'(bus.digit_seen_o), 32'h0);

    // Steady 1234 scan.
    repeat (2) scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
    check("t1_bcd", 32'(bus.bcd_o), 32'h1234);
    check("t1_err", 32'(bus.frame_err_o), 32'h0);

    // Switch value mid-scan.
    show(4'b0111, 7'h79, 8);
    show(4'b1011, 7'h24, 8);
    repeat (2) scan(7'h12, 7'h02, 7'h78, 7'h00, 8);
    check("t2_bcd", 32'(bus.bcd_o), 32'h5678);

    // Too-short dwell never captures; dwell of exactly S does.
    scan(7'h40, 7'h79, 7'h24, 7'h30, S - 1);
    check("t3_seen_short", 32'(bus.digit_seen_o), 32'h0);
    check("t3_bcd_hold", 32'(bus.bcd_o), 32'h5678);
    scan(7'h40, 7'h79, 7'h24, 7'h30, S);
    show(4'hF, 7'h7F, 3);
    check("t3_bcd_exact", 32'(bus.bcd_o), 32'h0123);

    // Hex glyph on anode0.
    scan(7'h79, 7'h24, 7'h30, 7'h08, 8);
    check("t4_nib", 32'(bus.bcd_o[3:0]), HexEn ? 32'hA : 32'hF);
    check("t4_err", 32'(bus.frame_err_o), HexEn ? 32'h0 : 32'h1);

    // Blank and two-hot gaps between digits.
    show(4'b0111, 7'h10, 6);
    show(4'b1111, 7'h7F, 5);
    show(4'b1011, 7'h00, 6);
    show(4'b1100, 7'h40, 5);
    show(4'b1101, 7'h78, 6);
    show(4'b1111, 7'h7F, 5);
    show(4'b1110, 7'h02, 8);
    check("t5_bcd", 32'(bus.bcd_o), 32'h9876);

    // Reset after two captures; next frame needs four fresh digits.
    show(4'b0111, 7'h79, 8);
    show(4'b1011, 7'h79, 8);
    do_reset();
    check("t6_seen", 32'(bus.digit_seen_o), 32'h0);
    check("t6_bcd", 32'(bus.bcd_o), 32'h0);
    show(4'b1101, 7'h24, 8);
    show(4'b1110, 7'h24, 8);
    check("t6_no_frame", 32'(bus.bcd_o), 32'h0);
    show(4'b0111, 7'h30, 8);
    show(4'b1011, 7'h19, 8);
    check("t6_frame", 32'(bus.bcd_o), 32'h3422);

    // Random intervals: mixed anode shapes, valid/invalid glyphs, dwell around the threshold.
    for (int n = 0; n < 300; n++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 6)      ra = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 8) ra = 4'hF;
        else            ra = two_hot[$urandom_range(0, 3)];
        if ($urandom_range(0, 9) < 7) rc = Glyph[$urandom_range(0, 15)];
        else                          rc = 7'($urandom);
      end while ({ra, rc} == prev);
      show(ra, rc, $urandom_range(S - 1, S + 5));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    show(4'hF, 7'h7F, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
